controlador_compuerta_param: RTL and testbench
==============================================

Name: controlador_compuerta_param

Overview:
Parametrised parking-gate controller, the synthesizable successor to the current fixed 8-bit gate logic. Validates a PIN entered by an arriving vehicle. Counts wrong attempts up to a configurable limit, opens the gate on a correct PIN and closes it when the vehicle has passed. Detects tailgating (a new vehicle present while the previous passage completes) and locks the gate until a correct PIN is entered. It is the DUT driven by the `probador` stimulus module.

Parameters:
PIN_W, 8, width of the PIN bus
PIN_CORRECTO, 8'h08 (PIN_W bits), valid PIN; must be nonzero
MAX_INTENTOS, 3, wrong entries that trigger Alarma; range 1..255
CONT_W, $clog2(MAX_INTENTOS+1), width of the attempt counter (derived; do not override)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Vehiculo  input  1  vehicle present at the entry sensor
Termino  input  1  vehicle has passed the exit sensor
Pin  input  PIN_W  PIN entry; all-zero = idle or no entry
Cerrado  output  1  gate closed
Abierto  output  1  gate open
Alarma  output  1  alarm (too many wrong PINs, or tailgating)
Bloqueo  output  1  gate locked (tailgating)
Intentos  output  CONT_W  wrong attempts in the current session

Behaviour:
- Reset (async assert, released synchronously on the first Clk edge after deassertion):
  - state = ESPERA, Intentos = 0, pin_prev = 0.
  - Cerrado = 1; Abierto, Alarma and Bloqueo = 0.
- PIN event: pin_evento = (Pin != 0) && (pin_prev == 0).
  - pin_prev is Pin registered each cycle.
  - A PIN held nonzero for N cycles counts as exactly one entry.
  - Pin must return to 0 before the next entry is recognised.
- PIN classification: correcto = pin_evento && (Pin == PIN_CORRECTO); incorrecto = pin_evento && !correcto.
- Moore outputs are decoded from the state register, so they change on the same edge as the state. There is no combinational path from inputs to outputs.
- States and outputs (Cerrado / Abierto / Alarma / Bloqueo):
  - ESPERA: 1/0/0/0
  - ESPERA_PIN: 1/0/0/0
  - ALARMA_PIN: 1/0/1/0
  - ABIERTO: 0/1/0/0
  - BLOQUEO: 1/0/1/1
- Transitions (evaluated each rising edge, in priority order):
  - ESPERA:
    - Vehiculo=1 -> ESPERA_PIN; Intentos <= 0.
    - Pin events in ESPERA are ignored.
  - ESPERA_PIN:
    - correcto -> ABIERTO; Intentos <= 0.
    - incorrecto -> Intentos <= Intentos+1. If Intentos+1 == MAX_INTENTOS, go to ALARMA_PIN.
    - Otherwise, Vehiculo=0 -> ESPERA; Intentos <= 0.
    - A PIN event takes precedence over Vehiculo falling in the same cycle.
  - ALARMA_PIN:
    - correcto -> ABIERTO; Intentos <= 0.
    - incorrecto is ignored; Intentos saturates at MAX_INTENTOS.
    - Vehiculo falling does not clear the alarm.
  - ABIERTO:
    - Termino=1 and Vehiculo=0 -> ESPERA.
    - Termino=1 and Vehiculo=1 -> BLOQUEO.
    - Termino=0 -> stay; Pin events are ignored.
  - BLOQUEO:
    - correcto -> ESPERA; Intentos <= 0.
    - All other inputs are ignored; Intentos is unchanged.
- Counter never wraps; MAX_INTENTOS=1 means the first wrong PIN raises Alarma.
- Latency: a Pin change sampled at edge k produces pin_evento at edge k. The state and outputs update at edge k (visible after edge k).
- Reset mid-operation from any state returns immediately (asynchronously) to reset values. A PIN held across reset release is not counted until Pin returns to 0 and is re-entered.
- Outputs are one-hot-consistent by construction: Cerrado == !Abierto at all times.

Decomposition:
- Shared package `compuerta_pkg`:
  - state enum: ESPERA, ESPERA_PIN, ALARMA_PIN, ABIERTO, BLOQUEO (3-bit binary encoding)
  - defaults PIN_W_DEF=8 and PIN_CORRECTO_DEF=8'h08
  - output-vector constants per state
- One sub-module: `detector_evento_pin` (parameter PIN_W).
  - Contains the pin_prev register and pin_evento generation.
  - Has the same Clk/Reset as the top.

Test Plan:
- Reset pulse at 5–15, Vehiculo=1 at 20. Apply Pin=8'hFF for one cycle, then 0, three times. -> Intentos goes 1, 2, 3 after each entry; Alarma=1 and Cerrado=1 after the third; Abierto stays 0.
- From ALARMA_PIN, apply Pin=8'h08 for one cycle. -> Alarma=0, Abierto=1, Cerrado=0, Intentos=0 on that edge.
- In ABIERTO, set Vehiculo=0 then Termino=1. -> returns to ESPERA: Cerrado=1, Abierto=0, Alarma=0.
- In ABIERTO, set Termino=1 with Vehiculo=1. -> Bloqueo=1, Alarma=1, Cerrado=1. A wrong Pin=8'h11 changes nothing. Then Pin=8'h08 -> ESPERA with all flags clear.
- Hold Pin=8'hFF nonzero for 5 cycles in ESPERA_PIN. -> Intentos increments once only (0->1). Then Vehiculo=0 with no event -> ESPERA, Intentos=0.
- Reset asserted asynchronously mid-ABIERTO (between edges). -> Cerrado=1 and Abierto=0 immediately, without waiting for Clk. Then Pin=8'h08 held through reset release -> no transition until Pin returns to 0 and is re-entered. Also rerun with MAX_INTENTOS=1: the first wrong PIN sets Alarma.

Source files
------------

// File: rtl/compuerta_pkg.sv
// Purpose: shared types and constants for the parking-gate controller.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: state enum, default PIN width/value, per-state output vectors
//           packed as {Cerrado, Abierto, Alarma, Bloqueo}, and their decoder.
package compuerta_pkg;

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    ESPERA_PIN = 3'd1,
    ALARMA_PIN = 3'd2,
    ABIERTO    = 3'd3,
    BLOQUEO    = 3'd4
  } estado_t;

  localparam int         PIN_W_DEF        = 8;
  localparam logic [7:0] PIN_CORRECTO_DEF = 8'h08;

  // {Cerrado, Abierto, Alarma, Bloqueo}
  localparam logic [3:0] SAL_ESPERA     = 4'b1000;
  localparam logic [3:0] SAL_ESPERA_PIN = 4'b1000;
  localparam logic [3:0] SAL_ALARMA_PIN = 4'b1010;
  localparam logic [3:0] SAL_ABIERTO    = 4'b0100;
  localparam logic [3:0] SAL_BLOQUEO    = 4'b1011;

  // Unused encodings decode as closed/idle so the gate never opens by accident.
  function automatic logic [3:0] salidas(input estado_t e);
    case (e)
      ESPERA:     salidas = SAL_ESPERA;
      ESPERA_PIN: salidas = SAL_ESPERA_PIN;
      ALARMA_PIN: salidas = SAL_ALARMA_PIN;
      ABIERTO:    salidas = SAL_ABIERTO;
      BLOQUEO:    salidas = SAL_BLOQUEO;
      default:    salidas = SAL_ESPERA;
    endcase
  endfunction

endpackage

// File: rtl/detector_evento_pin.sv
// Purpose: flags a new PIN entry (rising edge from all-zero to nonzero Pin).
// Latency: combinational on Pin; pin_prev is Pin delayed one Clk.
// Backpressure: none; Pin is sampled every cycle.
// Ports: Clk, Reset (async, active-high), Pin [PIN_W], pin_evento (1 cycle pulse).
module detector_evento_pin
  import compuerta_pkg::*;
#(
  parameter int PIN_W = PIN_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [PIN_W-1:0] Pin,
  output logic             pin_evento
);

  logic [PIN_W-1:0] pin_prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pin_prev <= '0;
    else       pin_prev <= Pin;
  end

  // A PIN held nonzero for several cycles produces a single event; it must
  // go back to zero before another entry is recognised.
  assign pin_evento = (Pin != '0) && (pin_prev == '0);

endmodule

// File: rtl/controlador_compuerta_param.sv
// Purpose: parking-gate controller; PIN check, wrong-attempt alarm, tailgating lock.
// Latency: a PIN entry sampled at edge k updates state/outputs at edge k (Moore outputs).
// Backpressure: none; all inputs are sampled every cycle.
// Ports: Clk, Reset (async, active-high), Vehiculo, Termino, Pin [PIN_W] ->
//        Cerrado, Abierto, Alarma, Bloqueo, Intentos [CONT_W].
module controlador_compuerta_param
  import compuerta_pkg::*;
#(
  parameter int               PIN_W        = PIN_W_DEF,
  parameter logic [PIN_W-1:0] PIN_CORRECTO = PIN_W'(PIN_CORRECTO_DEF),
  parameter int               MAX_INTENTOS = 3,
  parameter int               CONT_W       = $clog2(MAX_INTENTOS + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Vehiculo,
  input  logic              Termino,
  input  logic [PIN_W-1:0]  Pin,
  output logic              Cerrado,
  output logic              Abierto,
  output logic              Alarma,
  output logic              Bloqueo,
  output logic [CONT_W-1:0] Intentos
);

  localparam logic [CONT_W-1:0] MAX_C = CONT_W'(MAX_INTENTOS);

  estado_t           estado, estado_sig;
  logic [CONT_W-1:0] intentos_q, intentos_sig, intentos_mas1;
  logic              pin_evento, correcto, incorrecto;

  detector_evento_pin #(.PIN_W(PIN_W)) u_detector (
    .Clk        (Clk),
    .Reset      (Reset),
    .Pin        (Pin),
    .pin_evento (pin_evento)
  );

  assign correcto      = pin_evento && (Pin == PIN_CORRECTO);
  assign incorrecto    = pin_evento && !correcto;
  // Only used in ESPERA_PIN, where intentos_q < MAX_INTENTOS, so no overflow.
  assign intentos_mas1 = intentos_q + CONT_W'(1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado     <= ESPERA;
      intentos_q <= '0;
    end else begin
      estado     <= estado_sig;
      intentos_q <= intentos_sig;
    end
  end

  always_comb begin
    estado_sig   = estado;
    intentos_sig = intentos_q;
    case (estado)
      ESPERA: begin
        if (Vehiculo) begin
          estado_sig   = ESPERA_PIN;
          intentos_sig = '0;
        end
      end
      ESPERA_PIN: begin
        // A PIN entry wins over the vehicle leaving in the same cycle.
        if (correcto) begin
          estado_sig   = ABIERTO;
          intentos_sig = '0;
        end else if (incorrecto) begin
          intentos_sig = intentos_mas1;
          if (intentos_mas1 == MAX_C) estado_sig = ALARMA_PIN;
        end else if (!Vehiculo) begin
          estado_sig   = ESPERA;
          intentos_sig = '0;
        end
      end
      ALARMA_PIN: begin
        // Wrong entries and the vehicle leaving leave the alarm (and the
        // saturated counter) untouched; only the right PIN clears it.
        if (correcto) begin
          estado_sig   = ABIERTO;
          intentos_sig = '0;
        end
      end
      ABIERTO: begin
        if (Termino) estado_sig = Vehiculo ? BLOQUEO : ESPERA;
      end
      BLOQUEO: begin
        if (correcto) begin
          estado_sig   = ESPERA;
          intentos_sig = '0;
        end
      end
      default: begin
        estado_sig   = ESPERA;
        intentos_sig = '0;
      end
    endcase
  end

  assign {Cerrado, Abierto, Alarma, Bloqueo} = salidas(estado);
  assign Intentos = intentos_q;

endmodule

// File: tb/tb_controlador_compuerta_param.sv
module tb_controlador_compuerta_param;

  logic       Clk;
  logic       Reset;
  logic       Vehiculo, Termino;
  logic [7:0] Pin;
  logic       Cerrado, Abierto, Alarma, Bloqueo;
  logic [1:0] Intentos;

  // Second instance with MAX_INTENTOS = 1.
  logic       vb, tb_b;
  logic [7:0] pb;
  logic       cerrado_b, abierto_b, alarma_b, bloqueo_b;
  logic [0:0] intentos_b;

  int vecs  = 0;
  int fails = 0;

  controlador_compuerta_param dut (
    .Clk(Clk), .Reset(Reset), .Vehiculo(Vehiculo), .Termino(Termino), .Pin(Pin),
    .Cerrado(Cerrado), .Abierto(Abierto), .Alarma(Alarma), .Bloqueo(Bloqueo),
    .Intentos(Intentos)
  );

  controlador_compuerta_param #(.MAX_INTENTOS(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Vehiculo(vb), .Termino(tb_b), .Pin(pb),
    .Cerrado(cerrado_b), .Abierto(abierto_b), .Alarma(alarma_b), .Bloqueo(bloqueo_b),
    .Intentos(intentos_b)
  );

  // Posedges at 10, 20, 30, ...
  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {Cerrado, Abierto, Alarma, Bloqueo}
  function automatic logic [31:0] flags;
    return {28'd0, Cerrado, Abierto, Alarma, Bloqueo};
  endfunction

  function automatic logic [31:0] flags_b;
    return {28'd0, cerrado_b, abierto_b, alarma_b, bloqueo_b};
  endfunction

  initial begin
    Reset = 1'b0; Vehiculo = 1'b0; Termino = 1'b0; Pin = 8'h00;
    vb = 1'b0; tb_b = 1'b0; pb = 8'h00;

    // Reset pulse 5..15, checked asynchronously before any clock edge.
    #5 Reset = 1'b1;
    #1;
    chk("reset_flags",    flags(),   32'b1000);
    chk("reset_intentos", Intentos,  32'd0);
    chk("reset_flags_b",  flags_b(), 32'b1000);
    #9 Reset = 1'b0;
    tick;                                   // edge 20: stays ESPERA

    Vehiculo = 1'b1; vb = 1'b1;
    tick;                                   // -> ESPERA_PIN
    chk("espera_pin_flags", flags(), 32'b1000);
    chk("espera_pin_int",   Intentos, 32'd0);
    chk("b_espera_pin",     flags_b(), 32'b1000);

    // Three wrong entries (one cycle each); the first also hits instance B.
    for (int i = 1; i <= 3; i++) begin
      Pin = 8'hFF;
      if (i == 1) pb = 8'hFF;
      tick;
      chk($sformatf("wrong_%0d_int", i), Intentos, i);
      if (i == 1) begin
        chk("b_first_wrong_flags", flags_b(), 32'b1010);
        chk("b_first_wrong_int",   intentos_b, 32'd1);
      end
      Pin = 8'h00; pb = 8'h00;
      tick;
    end
    chk("alarm_flags", flags(), 32'b1010);

    // Another wrong PIN and the vehicle leaving keep the alarm; counter saturates.
    Pin = 8'hFF; tick; Pin = 8'h00; tick;
    chk("alarm_saturate", Intentos, 32'd3);
    Vehiculo = 1'b0; tick;
    chk("alarm_veh_gone", flags(), 32'b1010);

    // Correct PIN clears alarm and opens on that edge.
    Pin = 8'h08; pb = 8'h08; tick;
    chk("open_flags",  flags(),  32'b0100);
    chk("open_int",    Intentos, 32'd0);
    chk("b_open_flags", flags_b(), 32'b0100);
    Pin = 8'h00; pb = 8'h00; tick;

    // Vehicle gone, passage complete -> ESPERA.
    Termino = 1'b1; tick;
    chk("pass_done", flags(), 32'b1000);
    Termino = 1'b0;

    // Reopen, check ignored PIN in ABIERTO, then tailgating.
    Vehiculo = 1'b1; tick;
    Pin = 8'h08; tick; Pin = 8'h00; tick;
    chk("reopen", flags(), 32'b0100);
    Pin = 8'h11; tick; Pin = 8'h00; tick;
    chk("abierto_ignores_pin", flags(), 32'b0100);
    Termino = 1'b1; tick;
    chk("tailgate_lock", flags(), 32'b1011);
    Termino = 1'b0;
    Pin = 8'h11; tick; Pin = 8'h00; tick;
    chk("lock_wrong_pin", flags(),  32'b1011);
    chk("lock_int",       Intentos, 32'd0);
    Pin = 8'h08; tick;
    chk("unlock", flags(), 32'b1000);
    Pin = 8'h00; tick;                      // Vehiculo still 1 -> ESPERA_PIN

    // Held PIN counts once.
    Pin = 8'hFF;
    for (int i = 0; i < 5; i++) tick;
    chk("held_pin_once", Intentos, 32'd1);
    Pin = 8'h00; tick;
    chk("held_pin_release", Intentos, 32'd1);
    Vehiculo = 1'b0; tick;
    chk("leave_clears_int", Intentos, 32'd0);
    chk("leave_flags",      flags(),  32'b1000);

    // PIN event beats Vehiculo falling in the same cycle.
    Vehiculo = 1'b1; tick;
    Pin = 8'hFF; Vehiculo = 1'b0; tick;
    chk("pin_beats_leave", Intentos, 32'd1);
    Pin = 8'h00; tick;
    chk("then_leave", Intentos, 32'd0);

    // Asynchronous reset mid-ABIERTO, correct PIN held across release.
    Vehiculo = 1'b1; tick;
    Pin = 8'h08; tick;
    chk("pre_reset_open", flags(), 32'b0100);
    #3 Reset = 1'b1;
    #1;
    chk("async_reset_flags", flags(), 32'b1000);
    tick;
    Reset = 1'b0;
    tick; tick;                             // ESPERA -> ESPERA_PIN, held PIN not counted
    chk("held_across_reset_flags", flags(),  32'b1000);
    chk("held_across_reset_int",   Intentos, 32'd0);
    Pin = 8'h00; tick;
    Pin = 8'h08; tick;
    chk("reentered_opens", flags(), 32'b0100);
    Pin = 8'h00; tick;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
